// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction-image loader and reader.
package imem_pkg;

  localparam int unsigned IMEM_W    = 64;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = IMEM_W / BYTE_W;
  localparam int unsigned IDX_W     = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/imem_byte_reader.sv
// Captures a packed 64-bit instruction image and streams it out byte-wise, oldest first.
// Optional IMEM_LOOP_EN: replay the captured image forever, done pulses once per pass.
module imem_byte_reader
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [IMEM_W-1:0] imem_in,
  input  logic              fetch_ready,
  output logic [BYTE_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [IDX_W-1:0]  pc_out,
  output logic              busy,
  output logic              done
);

  state_t            state, state_n;
  logic [IMEM_W-1:0] shreg, shreg_n;
  logic [IDX_W-1:0]  pc_n;
  logic              valid_n, busy_n, done_n;
  logic              xfer, last;

`ifdef IMEM_LOOP_EN
  logic [IMEM_W-1:0] img_copy, img_copy_n;
`endif

  // Presented byte is always the head of the shift register; it empties to zero after the last byte.
  assign instr_out = shreg[IMEM_W-1 -: BYTE_W];
  assign xfer      = instr_valid & fetch_ready;
  assign last      = (pc_out == IDX_W'(NUM_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef IMEM_LOOP_EN
      img_copy    <= '0;
`endif
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      pc_out      <= pc_n;
      instr_valid <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
`ifdef IMEM_LOOP_EN
      img_copy    <= img_copy_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    pc_n    = pc_out;
    valid_n = instr_valid;
    busy_n  = busy;
`ifdef IMEM_LOOP_EN
    done_n     = 1'b0;
    img_copy_n = img_copy;
`else
    done_n  = done;
`endif

    unique case (state)
      IDLE, DONE: begin
        if (load) begin
          state_n = STREAM;
          shreg_n = imem_in;
          pc_n    = '0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          done_n  = 1'b0;
`ifdef IMEM_LOOP_EN
          img_copy_n = imem_in;
`endif
        end
      end

      STREAM: begin
        if (xfer) begin
          pc_n = pc_out + IDX_W'(1);
          if (last) begin
            done_n = 1'b1;
`ifdef IMEM_LOOP_EN
            shreg_n = img_copy;
`else
            state_n = DONE;
            shreg_n = shreg << BYTE_W;
            valid_n = 1'b0;
            busy_n  = 1'b0;
`endif
          end else begin
            shreg_n = shreg << BYTE_W;
          end
        end
      end

      default: begin
        state_n = IDLE;
        shreg_n = '0;
        pc_n    = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_byte_reader.sv
// Scoreboard bench for imem_byte_reader; expected bytes queued at load, popped on each transfer.
module tb_imem_byte_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [63:0] imem_in;
  logic        fetch_ready;
  logic [7:0]  instr_out;
  logic        instr_valid;
  logic [2:0]  pc_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails  = 0;

  logic [7:0] exp_q[$];
  logic [2:0] exp_pc_q[$];

  imem_byte_reader dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .imem_in     (imem_in),
    .fetch_ready (fetch_ready),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_image(logic [63:0] img);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(img[63 - 8*i -: 8]);
      exp_pc_q.push_back(3'(i));
    end
  endtask

  task automatic do_load(logic [63:0] img);
    imem_in = img;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic wait_done(int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check("done_reached", 64'(done), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && instr_valid && fetch_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_transfer: got instr %0h pc %0d with empty scoreboard", instr_out, pc_out);
      end else begin
        check("instr_out", 64'(instr_out), 64'(exp_q.pop_front()));
        check("pc_out", 64'(pc_out), 64'(exp_pc_q.pop_front()));
      end
    end
  end

  initial begin
    rst         = 1'b1;
    load        = 1'b1;
    fetch_ready = 1'b1;
    imem_in     = 64'h0123456789ABCDEF;
    tick();
    tick();
    check("rst_instr_out", 64'(instr_out), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_pc", 64'(pc_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst  = 1'b0;
    load = 1'b0;
    tick();
    check("idle_no_valid", 64'(instr_valid), 64'd0);

`ifdef IMEM_LOOP_EN
    // Replay: 20 transfers, done pulses after every 8th, valid never drops.
    do_load(64'h0123456789ABCDEF);
    for (int p = 0; p < 3; p++) push_image(64'h0123456789ABCDEF);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("loop_valid", 64'(instr_valid), 64'd1);
      check("loop_done", 64'(done), 64'((k % 8) == 0));
    end
    rst = 1'b1;
    exp_q.delete();
    exp_pc_q.delete();
    tick();
    check("loop_rst_valid", 64'(instr_valid), 64'd0);
    check("loop_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
`else
    // Basic stream at full throughput.
    do_load(64'h0123456789ABCDEF);
    push_image(64'h0123456789ABCDEF);
    check("first_valid", 64'(instr_valid), 64'd1);
    check("first_busy", 64'(busy), 64'd1);
    check("first_instr", 64'(instr_out), 64'h01);
    repeat (8) tick();
    check("end_valid", 64'(instr_valid), 64'd0);
    check("end_done", 64'(done), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("end_pc", 64'(pc_out), 64'd0);
    check("end_instr", 64'(instr_out), 64'd0);
    check("end_queue", 64'(exp_q.size()), 64'd0);
    tick();
    check("done_sticky", 64'(done), 64'd1);
    check("done_no_valid", 64'(instr_valid), 64'd0);

    // Backpressure while 8'h45 is presented.
    do_load(64'h0123456789ABCDEF);
    push_image(64'h0123456789ABCDEF);
    tick();
    tick();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_instr", 64'(instr_out), 64'h45);
      check("bp_pc", 64'(pc_out), 64'd2);
      check("bp_valid", 64'(instr_valid), 64'd1);
    end
    fetch_ready = 1'b1;
    tick();
    check("bp_resume_instr", 64'(instr_out), 64'h67);
    check("bp_resume_pc", 64'(pc_out), 64'd3);
    wait_done(20);

    // Load during stream is ignored; reload after done streams the new image.
    do_load(64'h0123456789ABCDEF);
    push_image(64'h0123456789ABCDEF);
    repeat (3) tick();
    check("mid_pc", 64'(pc_out), 64'd3);
    do_load(64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(20);
    do_load(64'hFFFF_FFFF_FFFF_FFFF);
    push_image(64'hFFFF_FFFF_FFFF_FFFF);
    check("reload_instr", 64'(instr_out), 64'hFF);
    wait_done(20);

    // Reset mid-stream at pc_out = 5, then restart.
    do_load(64'h0123456789ABCDEF);
    push_image(64'h0123456789ABCDEF);
    repeat (5) tick();
    check("pre_rst_pc", 64'(pc_out), 64'd5);
    rst = 1'b1;
    tick();
    check("mrst_valid", 64'(instr_valid), 64'd0);
    check("mrst_pc", 64'(pc_out), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_leftover", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    exp_pc_q.delete();
    rst = 1'b0;
    do_load(64'h0123456789ABCDEF);
    push_image(64'h0123456789ABCDEF);
    check("restart_instr", 64'(instr_out), 64'h01);
    check("restart_pc", 64'(pc_out), 64'd0);
    wait_done(20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/imem_byte_reader.md
Name: imem_byte_reader

Overview:
- Read-side counterpart of the byte-wise instruction loader.
- The loader packs 8-bit entries into a 64-bit instruction image. This block captures that image and streams it back as 8-bit instructions to the fetch stage, in entry order.
- Uses a valid/ready handshake.
- Sits between the instruction-image register and the IF stage of the 5-stage 8-bit pipeline.

Parameters:
- IMEM_W, 64, width of the packed instruction image.
- BYTE_W, 8, instruction width.
- NUM_BYTES, IMEM_W/BYTE_W (8), instructions per image. Derived; not overridden.
- IDX_W, $clog2(NUM_BYTES) (3), width of the index counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle pulse: capture imem_in and start streaming.
- imem_in  input  IMEM_W  packed image. The oldest entry is in bits [IMEM_W-1 -: BYTE_W].
- fetch_ready  input  1  IF stage accepts instr_out this cycle.
- instr_out  output  BYTE_W  current instruction, registered.
- instr_valid  output  1  instr_out holds a valid instruction.
- pc_out  output  IDX_W  index of the instruction currently presented (0 = oldest).
- busy  output  1  high in STREAM.
- done  output  1  sticky: whole image delivered.

Behaviour:
- Interface rule: one clock, clk; rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - instr_out=0, instr_valid=0, pc_out=0, busy=0, done=0.
  - Shift register cleared.
  - rst overrides load and fetch_ready on the same edge.
- States:
  - IDLE: no data.
  - STREAM: presenting instructions.
  - DONE: all NUM_BYTES transferred.
- IDLE/DONE, load=1:
  - shreg <= imem_in; pc_out <= 0; done <= 0; state -> STREAM.
  - instr_valid=1 with instr_out=imem_in[63:56] from the next cycle. Load-to-first-valid latency is 1 cycle.
- STREAM:
  - instr_out always equals shreg[IMEM_W-1 -: BYTE_W].
  - A transfer is instr_valid & fetch_ready at a rising edge. On a transfer, shreg shifts left by BYTE_W (zero fill) and pc_out increments.
- Backpressure:
  - While fetch_ready=0, instr_out, pc_out and instr_valid hold stable.
  - instr_valid never drops without a transfer.
- Last transfer (pc_out == NUM_BYTES-1 and a transfer occurs):
  - state -> DONE; instr_valid <= 0; busy <= 0; done <= 1; pc_out <= 0 (wrap); instr_out <= 0.
- Throughput: with fetch_ready held at 1, the 8 instructions appear on 8 consecutive cycles, and done rises on the edge of the 8th transfer.
- load while in STREAM: ignored. Streaming continues and shreg is unchanged.
- fetch_ready while in IDLE/DONE: ignored. No state change.
- Arithmetic: pc_out is a modulo-NUM_BYTES counter; no other arithmetic.

Optional Feature:
- Macro: IMEM_LOOP_EN.
- Defined:
  - A second register, img_copy, holds the captured image.
  - After the last transfer, shreg reloads from img_copy, pc_out wraps to 0, and the state stays STREAM with instr_valid=1. The image replays indefinitely.
  - done pulses high for exactly one cycle per completed pass instead of being sticky.
  - load in STREAM is still ignored; only rst stops streaming.
- Undefined: behaviour exactly as above; no img_copy register.

Decomposition:
- Shared package imem_pkg:
  - IMEM_W, BYTE_W, NUM_BYTES, IDX_W.
  - Enumerated state type {IDLE, STREAM, DONE} (2 bits).
  - The loader uses the same IMEM_W/BYTE_W constants.
- The block stays single-module. The shift register and counter are too small to justify a sub-module.
- If a sub-module is wanted, it is imem_shift_unit (shreg plus pc counter), with the FSM in the parent.

Test Plan:
- Reset: rst=1 for 2 cycles with load=1 and fetch_ready=1 -> all outputs 0, state IDLE.
- Basic stream: load imem_in=64'h0123456789ABCDEF, fetch_ready=1 ->
  - instr_out 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles, with pc_out 0..7.
  - Next cycle: instr_valid=0, done=1, busy=0.
- Backpressure: same image, fetch_ready=0 for 3 cycles while 8'h45 is presented -> instr_out=45, pc_out=2, instr_valid=1 stable throughout; 67 follows one cycle after fetch_ready returns to 1.
- Load during stream: at pc_out=3, pulse load with 64'hFFFF_FFFF_FFFF_FFFF -> sequence continues 67,89,AB,CD,EF unchanged. A reload after done then streams FF x8.
- Reset mid-stream: rst=1 at pc_out=5 -> next cycle instr_valid=0, pc_out=0, done=0, IDLE; a new load restarts from byte 0.
- Loop (IMEM_LOOP_EN): load 64'h0123456789ABCDEF, fetch_ready=1 for 20 cycles -> ...,EF,01,23,...; done high for 1 cycle after each EF; instr_valid never drops.
